decode_sel_sequencer: RTL

//   Upstream driver for the 2-to-4 select decoder. Steps a select index

---
 rtl/decode_sel_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/decode_sel_sequencer.sv
// decode_sel_sequencer
//   Drives the select input of a 2**SEL_W-way decoder. It steps through every
//   code, holding each one for (dwell+1) clocks, and either makes one sweep or
//   loops until stopped.
//   Optional build macro SEL_GRAY_EN: codes are emitted in binary-reflected
//   Gray order instead of binary order. Ports and timing do not change.
module decode_sel_sequencer #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0]   IDX_ZERO  = {SEL_W{1'b0}};
    localparam logic [SEL_W-1:0]   IDX_LAST  = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0]   IDX_ONE   = {{(SEL_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] CNT_ZERO  = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] CNT_ONE   = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [SEL_W-1:0]   idx_r;      // binary position within the sweep
    logic [DWELL_W-1:0] cnt_r;      // cycles the current code has been shown
    logic [DWELL_W-1:0] dwell_r;    // dwell captured at start
    logic               loop_r;     // loop_mode captured at start

    logic [SEL_W-1:0]   idx_next_s;
    logic               expire_s;
    logic               last_s;

    // Maps a sweep position to the code placed on sel.
    function automatic logic [SEL_W-1:0] code_of(input logic [SEL_W-1:0] i);
`ifdef SEL_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    // Next sweep position and end-of-dwell / end-of-sweep flags.
    always_comb begin
        idx_next_s = idx_r + IDX_ONE;
        last_s     = 1'b0;
        if (cnt_r == dwell_r) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
        if (idx_r == IDX_LAST) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Sweep state machine; every output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            idx_r     <= IDX_ZERO;
            cnt_r     <= CNT_ZERO;
            dwell_r   <= CNT_ZERO;
            loop_r    <= 1'b0;
            sel       <= IDX_ZERO;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start && !stop) begin
                        state_r   <= ST_RUN;
                        dwell_r   <= dwell;
                        loop_r    <= loop_mode;
                        idx_r     <= IDX_ZERO;
                        cnt_r     <= CNT_ZERO;
                        sel       <= code_of(IDX_ZERO);
                        sel_valid <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        // Abort wins over advance and completion.
                        state_r   <= ST_IDLE;
                        idx_r     <= IDX_ZERO;
                        cnt_r     <= CNT_ZERO;
                        sel       <= IDX_ZERO;
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (expire_s) begin
                        cnt_r <= CNT_ZERO;
                        if (last_s && !loop_r) begin
                            // sel keeps the last code while done pulses.
                            state_r   <= ST_DONE;
                            sel_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx_r <= idx_next_s;
                            sel   <= code_of(idx_next_s);
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    sel_valid <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    idx_r     <= IDX_ZERO;
                    cnt_r     <= CNT_ZERO;
                    sel       <= IDX_ZERO;
                    sel_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
